// File: rtl/ram_latency_model.sv
// Word-addressed RAM responder with programmable wait states.
// A request must stay stable for LAT+1 cycles of BUSY before ACCESS is granted.
module ram_latency_model #(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [1:0]  ramstate,
  output logic [31:0] ramload
);

  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} state_t;

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(4 * DEPTH);

  logic          active;
  logic [3:0]    cnt;
  logic [31:0]   req_addr;
  logic          req_wen;
  logic [31:0]   mem [DEPTH];

  state_t        st;
  logic          oor, match, capture, dec, clr, wr;
  logic [AW-1:0] idx;

  assign idx   = ramaddr[AW+1:2];
  assign oor   = {1'b0, ramaddr} >= LIMIT;
  assign match = active && (ramaddr == req_addr) && (ramWEN == req_wen);

  always_comb begin
    st      = FREE;
    capture = 1'b0;
    dec     = 1'b0;
    clr     = 1'b0;
    wr      = 1'b0;
    ramload = '0;
    if (!nRST) begin
      st = FREE;
    end else if (ramREN && ramWEN) begin
      st  = ERROR;
      clr = 1'b1;
    end else if ((ramREN || ramWEN) && oor) begin
      st  = ERROR;
      clr = 1'b1;
    end else if (!ramREN && !ramWEN) begin
      st  = FREE;
      clr = 1'b1;
    end else if (!match) begin
      st      = BUSY;
      capture = 1'b1;
    end else if (cnt != 4'd0) begin
      st  = BUSY;
      dec = 1'b1;
    end else begin
      st = ACCESS;
      if (ramWEN) wr = 1'b1;
      else        ramload = mem[idx];
    end
  end

  assign ramstate = st;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      active   <= 1'b0;
      cnt      <= '0;
      req_addr <= '0;
      req_wen  <= 1'b0;
    end else if (clr) begin
      active <= 1'b0;
    end else if (capture) begin
      active   <= 1'b1;
      req_addr <= ramaddr;
      req_wen  <= ramWEN;
      cnt      <= 4'(LAT);
    end else if (dec) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Memory clears with reset so every bench starts from a known zero image.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[idx] <= ramstore;
    end
  end

endmodule

// File: tb/tb_ram_latency_model.sv
// Scoreboarded random bench: two responders (LAT=2 and LAT=0) share one request stream.
module tb_ram_latency_model;
  localparam int DEPTH = 1024;

  logic        CLK = 1'b0;
  logic        nRST, ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [1:0]  st0, st1;
  logic [31:0] ld0, ld1;

  always #5 CLK = ~CLK;

  ram_latency_model #(.LAT(2), .DEPTH(DEPTH)) dut0 (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramstate(st0), .ramload(ld0));
  ram_latency_model #(.LAT(0), .DEPTH(DEPTH)) dut1 (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramstate(st1), .ramload(ld1));

  typedef struct {
    logic [1:0]  st [2];
    logic [31:0] ld [2];
  } exp_t;

  exp_t        q[$];
  int          passed = 0, total = 0;
  int          lats [2] = '{2, 0};
  logic [31:0] mm [2][DEPTH];
  int          run = 0;
  bit          lv = 0, lw = 0;
  logic [31:0] la = '0;
  bit          done = 0;

  // Reference: a request earns ACCESS once it has been seen unchanged for LAT+1 earlier cycles.
  task automatic cyc(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input bit rs);
    exp_t e;
    bit   req, oor, same, ok;
    int   idx;
    @(negedge CLK);
    nRST = rs; ramREN = r; ramWEN = w; ramaddr = a; ramstore = d;
    req  = r | w;
    oor  = a >= 32'(4 * DEPTH);
    ok   = req && !(r && w) && !oor;
    same = lv && a == la && w == lw;
    idx  = int'(a[31:2]) % DEPTH;
    for (int k = 0; k < 2; k++) begin
      e.st[k] = 2'd0; e.ld[k] = '0;
      if (!rs)                 e.st[k] = 2'd0;
      else if (r && w)         e.st[k] = 2'd3;
      else if (req && oor)     e.st[k] = 2'd3;
      else if (!req)           e.st[k] = 2'd0;
      else if (same && run >= lats[k] + 1) begin
        e.st[k] = 2'd2;
        if (w) mm[k][idx] = d;
        else   e.ld[k] = mm[k][idx];
      end else                 e.st[k] = 2'd1;
    end
    q.push_back(e);
    if (!rs) begin
      for (int k = 0; k < 2; k++) for (int i = 0; i < DEPTH; i++) mm[k][i] = '0;
      lv = 0; run = 0;
    end else if (ok) begin
      run = same ? run + 1 : 1;
      lv = 1; la = a; lw = w;
    end else begin
      lv = 0; run = 0;
    end
  endtask

  task automatic hold(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) cyc(r, w, a, d, 1'b1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state_lat2", 32'(st0), 32'(e.st[0]));
        chk("load_lat2",  ld0,      e.ld[0]);
        chk("state_lat0", 32'(st1), 32'(e.st[1]));
        chk("load_lat0",  ld1,      e.ld[1]);
      end
    end
  end

  initial begin : driver
    logic [31:0] addrs [8] = '{32'h0, 32'h4, 32'h40, 32'h44, 32'h10, 32'h1000, 32'hFFC, 32'h8};
    for (int k = 0; k < 2; k++) for (int i = 0; i < DEPTH; i++) mm[k][i] = '0;
    nRST = 0; ramREN = 0; ramWEN = 0; ramaddr = '0; ramstore = '0;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 32'h40, 0, 0);                       // request held under reset -> FREE
    hold(1, 0, 32'h40, 0, 5);                      // read 0x40: BUSY x3, ACCESS 0
    hold(0, 0, 0, 0, 1);
    hold(0, 1, 32'h40, 32'hDEADBEEF, 4);           // write ACCESS at cycle 3
    hold(0, 0, 0, 0, 1);
    hold(1, 0, 32'h40, 0, 4);                      // read back DEADBEEF
    hold(1, 0, 32'h40, 0, 2);                      // fresh? no: continues holding
    hold(0, 0, 0, 0, 1);
    hold(1, 0, 32'h40, 0, 2);
    hold(1, 0, 32'h44, 0, 4);                      // switch mid-wait restarts
    hold(0, 0, 0, 0, 1);
    hold(1, 1, 32'h10, 32'h55, 3);                 // REN&WEN -> ERROR
    hold(1, 0, 32'h10, 0, 4);                      // and nothing got written
    hold(1, 0, 32'h1000, 0, 2);                    // out of range
    hold(0, 1, 32'hFFFFFFFC, 32'h1, 2);
    hold(0, 0, 0, 0, 1);
    hold(0, 1, 32'h8, 32'h12345678, 2);            // LAT=0 -> ACCESS on cycle 1
    cyc(0, 1, 32'h8, 32'h9ABCDEF0, 1);             // store change during hold is not a restart
    hold(0, 1, 32'h8, 32'h0BADF00D, 2);
    hold(1, 0, 32'h8, 0, 4);
    hold(1, 0, 32'h80, 0, 2);                      // reset during BUSY
    cyc(1, 0, 32'h80, 0, 0);
    cyc(1, 0, 32'h80, 0, 0);
    hold(1, 0, 32'h80, 0, 4);
    hold(1, 0, 32'h40, 0, 4);                      // memory cleared by reset
    for (int n = 0; n < 400; n++) begin
      bit r, w;
      int sel, len;
      logic [31:0] a, d;
      sel = $urandom_range(0, 9);
      r = (sel < 4) || (sel == 9);
      w = (sel >= 4 && sel < 8) || (sel == 9);
      if (sel == 8) begin r = 0; w = 0; end
      a = addrs[$urandom_range(0, 7)];
      d = $urandom;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) d = $urandom;
        cyc(r, w, a, d, $urandom_range(0, 59) != 0);
      end
    end
    cyc(0, 0, 0, 0, 1);
    @(negedge CLK);
    #3;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    done = 1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    if (!done) begin
      $display("FAIL timeout: bench did not finish, passed %0d of %0d", passed, total);
      $fatal(1);
    end
  end
endmodule
